// File: rtl/panel_timing_seq.sv
// Frame timing sequencer for the panel gate driver and source mux: global reset,
// line scan with rotating CKV phases and CKH sub-phases, then vertical blanking.
module panel_timing_seq #(
   parameter int H_TOTAL     = 12,
   parameter int CKH_W       = 4,
   parameter int CKV_GAP     = 2,
   parameter int LINES       = 8,
   parameter int VBLANK      = 2,
   parameter int GRST_CYCLES = 5
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic start,
   input  logic cont,
   input  logic stop_req,
   input  logic scan_dir,
   output logic stv1,
   output logic ckv1,
   output logic ckv2,
   output logic ckv3,
   output logic ckv4,
   output logic ckv5,
   output logic ckv6,
   output logic ckh1,
   output logic ckh2,
   output logic ckh3,
   output logic grst,
   output logic gas,
   output logic u2d,
   output logic d2u,
   output logic busy,
   output logic frame_done
);

   localparam int CW = 16;
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] L_LAST   = CW'(LINES - 1);
   localparam logic [CW-1:0] B_LAST   = CW'((VBLANK > 0) ? (VBLANK - 1) : 0);
   localparam logic [CW-1:0] G_LAST   = CW'(GRST_CYCLES - 1);
   localparam logic [CW-1:0] G_END    = CW'(H_TOTAL - CKV_GAP);
   localparam logic [CW-1:0] CKH1_END = CW'(CKH_W);
   localparam logic [CW-1:0] CKH2_END = CW'(2 * CKH_W);
   localparam logic [CW-1:0] CKH3_END = CW'(3 * CKH_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRST  = 2'd1,
      S_SCAN  = 2'd2,
      S_BLANK = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_h_cnt;
   logic [CW-1:0]   w_h_nxt;
   logic [CW-1:0]   r_line_cnt;
   logic [CW-1:0]   w_line_nxt;
   logic [CW-1:0]   r_grst_cnt;
   logic [CW-1:0]   w_grst_nxt;
   logic [2:0]      r_ph;
   logic [2:0]      w_ph_nxt;
   logic            r_stop_pend;
   logic            w_stop_pend_nxt;
   logic            r_dir_lat;
   logic            w_dir_nxt;
   logic            w_stop_eff;
   logic            w_frame_end;

   logic            w_scan;
   logic            w_g;
   logic [2:0]      w_ckv_sel;
   logic [5:0]      w_ckv;
   logic [2:0]      w_ckh;

   logic            r_stv1;
   logic [5:0]      r_ckv;
   logic [2:0]      r_ckh;
   logic            r_grst;
   logic            r_u2d;
   logic            r_d2u;
   logic            r_busy;
   logic            r_frame_done;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_h_cnt     <= '0;
         r_line_cnt  <= '0;
         r_grst_cnt  <= '0;
         r_ph        <= '0;
         r_stop_pend <= 1'b0;
         r_dir_lat   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_h_cnt     <= w_h_nxt;
         r_line_cnt  <= w_line_nxt;
         r_grst_cnt  <= w_grst_nxt;
         r_ph        <= w_ph_nxt;
         r_stop_pend <= w_stop_pend_nxt;
         r_dir_lat   <= w_dir_nxt;
      end
   end

   // r_line_cnt counts active lines in SCAN and blanking lines in BLANK;
   // r_ph tracks line_cnt mod 6 so no divider is needed for the CKV rotation.
   always_comb begin
      w_state_nxt     = r_state;
      w_h_nxt         = r_h_cnt;
      w_line_nxt      = r_line_cnt;
      w_grst_nxt      = r_grst_cnt;
      w_ph_nxt        = r_ph;
      w_stop_pend_nxt = r_stop_pend;
      w_dir_nxt       = r_dir_lat;
      w_frame_end     = 1'b0;
      w_stop_eff      = r_stop_pend | stop_req;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt     = S_GRST;
               w_grst_nxt      = '0;
               w_dir_nxt       = scan_dir;
               w_stop_pend_nxt = 1'b0;
            end
         end
         S_GRST: begin
            w_stop_pend_nxt = w_stop_eff;
            if (r_grst_cnt == G_LAST) begin
               w_state_nxt = S_SCAN;
               w_h_nxt     = '0;
               w_line_nxt  = '0;
               w_ph_nxt    = '0;
               w_grst_nxt  = '0;
            end else begin
               w_grst_nxt = r_grst_cnt + ONE;
            end
         end
         S_SCAN: begin
            w_stop_pend_nxt = w_stop_eff;
            if (r_h_cnt == H_LAST) begin
               w_h_nxt = '0;
               if (r_line_cnt == L_LAST) begin
                  w_line_nxt = '0;
                  w_ph_nxt   = '0;
                  if (VBLANK == 0) begin
                     w_frame_end = 1'b1;
                  end else begin
                     w_state_nxt = S_BLANK;
                  end
               end else begin
                  w_line_nxt = r_line_cnt + ONE;
                  w_ph_nxt   = (r_ph == 3'd5) ? 3'd0 : (r_ph + 3'd1);
               end
            end else begin
               w_h_nxt = r_h_cnt + ONE;
            end
         end
         S_BLANK: begin
            w_stop_pend_nxt = w_stop_eff;
            if (r_h_cnt == H_LAST) begin
               w_h_nxt = '0;
               if (r_line_cnt == B_LAST) begin
                  w_line_nxt  = '0;
                  w_frame_end = 1'b1;
               end else begin
                  w_line_nxt = r_line_cnt + ONE;
               end
            end else begin
               w_h_nxt = r_h_cnt + ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // A stop arriving in the very last blank cycle still wins over cont.
      if (w_frame_end) begin
         w_ph_nxt = '0;
         if (cont && !w_stop_eff) begin
            w_state_nxt = S_SCAN;
         end else begin
            w_state_nxt = S_IDLE;
         end
      end
   end

   // Strobes decode the next state so they line up with the counters they reflect.
   always_comb begin
      w_scan    = (w_state_nxt == S_SCAN);
      w_g       = w_scan && (w_h_nxt < G_END);
      w_ckv_sel = w_dir_nxt ? (3'd5 - w_ph_nxt) : w_ph_nxt;
      for (int k = 0; k < 6; k++) begin
         w_ckv[k] = w_g && (w_ckv_sel == 3'(k));
      end
      w_ckh[0] = w_scan && (w_h_nxt < CKH1_END);
      w_ckh[1] = w_scan && (w_h_nxt >= CKH1_END) && (w_h_nxt < CKH2_END);
      w_ckh[2] = w_scan && (w_h_nxt >= CKH2_END) && (w_h_nxt < CKH3_END);
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_stv1       <= 1'b0;
         r_ckv        <= '0;
         r_ckh        <= '0;
         r_grst       <= 1'b0;
         r_u2d        <= 1'b1;
         r_d2u        <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_stv1       <= w_g && (w_line_nxt == '0);
         r_ckv        <= w_ckv;
         r_ckh        <= w_ckh;
         r_grst       <= (w_state_nxt == S_GRST);
         r_u2d        <= ~w_dir_nxt;
         r_d2u        <= w_dir_nxt;
         r_busy       <= (w_state_nxt != S_IDLE);
         r_frame_done <= w_frame_end;
      end
   end

   assign stv1       = r_stv1;
   assign ckv1       = r_ckv[0];
   assign ckv2       = r_ckv[1];
   assign ckv3       = r_ckv[2];
   assign ckv4       = r_ckv[3];
   assign ckv5       = r_ckv[4];
   assign ckv6       = r_ckv[5];
   assign ckh1       = r_ckh[0];
   assign ckh2       = r_ckh[1];
   assign ckh3       = r_ckh[2];
   assign grst       = r_grst;
   assign gas        = r_grst;
   assign u2d        = r_u2d;
   assign d2u        = r_d2u;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_panel_timing_seq.sv
// Bench for panel_timing_seq: directed frames on a default instance and a
// VBLANK=0 instance, expected strobe vectors queued at stimulus time.
module tb_panel_timing_seq;

   localparam int TB_G   = 5;
   localparam int TB_H   = 12;
   localparam int TB_GAP = 2;
   localparam int TB_CW  = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic start_a, cont_a, stop_a, dir_a;
   logic start_b, cont_b, stop_b, dir_b;

   logic stv1_a, ckv1_a, ckv2_a, ckv3_a, ckv4_a, ckv5_a, ckv6_a;
   logic ckh1_a, ckh2_a, ckh3_a, grst_a, gas_a, u2d_a, d2u_a, busy_a, fd_a;
   logic stv1_b, ckv1_b, ckv2_b, ckv3_b, ckv4_b, ckv5_b, ckv6_b;
   logic ckh1_b, ckh2_b, ckh3_b, grst_b, gas_b, u2d_b, d2u_b, busy_b, fd_b;

   logic [15:0] obs_a, obs_b;
   logic [15:0] q_exp[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   panel_timing_seq u_dut_a (
      .clk_sys(clk), .rst_n(rst_n), .start(start_a), .cont(cont_a),
      .stop_req(stop_a), .scan_dir(dir_a), .stv1(stv1_a),
      .ckv1(ckv1_a), .ckv2(ckv2_a), .ckv3(ckv3_a), .ckv4(ckv4_a), .ckv5(ckv5_a), .ckv6(ckv6_a),
      .ckh1(ckh1_a), .ckh2(ckh2_a), .ckh3(ckh3_a), .grst(grst_a), .gas(gas_a),
      .u2d(u2d_a), .d2u(d2u_a), .busy(busy_a), .frame_done(fd_a)
   );

   panel_timing_seq #(.LINES(4), .VBLANK(0)) u_dut_b (
      .clk_sys(clk), .rst_n(rst_n), .start(start_b), .cont(cont_b),
      .stop_req(stop_b), .scan_dir(dir_b), .stv1(stv1_b),
      .ckv1(ckv1_b), .ckv2(ckv2_b), .ckv3(ckv3_b), .ckv4(ckv4_b), .ckv5(ckv5_b), .ckv6(ckv6_b),
      .ckh1(ckh1_b), .ckh2(ckh2_b), .ckh3(ckh3_b), .grst(grst_b), .gas(gas_b),
      .u2d(u2d_b), .d2u(d2u_b), .busy(busy_b), .frame_done(fd_b)
   );

   assign obs_a = {busy_a, fd_a, d2u_a, u2d_a, gas_a, grst_a, ckh3_a, ckh2_a, ckh1_a,
                   ckv6_a, ckv5_a, ckv4_a, ckv3_a, ckv2_a, ckv1_a, stv1_a};
   assign obs_b = {busy_b, fd_b, d2u_b, u2d_b, gas_b, grst_b, ckh3_b, ckh2_b, ckh1_b,
                   ckv6_b, ckv5_b, ckv4_b, ckv3_b, ckv2_b, ckv1_b, stv1_b};

   // Expected strobe vector t cycles after the start-drive edge, for a run of nfr frames.
   function automatic logic [15:0] exp_vec(input int t, input bit dir, input int nfr,
                                           input int lines, input int vbl);
      int p, s, sp, line, h, idx;
      logic busy, fd, grs, stv, g;
      logic [5:0] ckv;
      logic [2:0] ckh;
      busy = 1'b0; fd = 1'b0; grs = 1'b0; stv = 1'b0; ckv = '0; ckh = '0;
      p = (lines + vbl) * TB_H;
      s = t - TB_G - 1;
      if (t >= 1 && t <= TB_G) begin
         busy = 1'b1;
         grs  = 1'b1;
      end else if (t > TB_G) begin
         if (s < nfr * p) begin
            busy = 1'b1;
            fd   = (s > 0) && (s % p == 0);
            sp   = s % p;
            if (sp < lines * TB_H) begin
               line = sp / TB_H;
               h    = sp % TB_H;
               g    = (h < TB_H - TB_GAP);
               stv  = g && (line == 0);
               idx  = dir ? (5 - (line % 6)) : (line % 6);
               ckv[idx] = g;
               if (h < 3 * TB_CW) ckh[h / TB_CW] = 1'b1;
            end
         end else if (s == nfr * p) begin
            fd = 1'b1;
         end
      end
      return {busy, fd, dir, ~dir, grs, grs, ckh, ckv, stv};
   endfunction

   task automatic check(input string tag, input int t, input logic [15:0] obs,
                        input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, expv);
      end
   endtask

   task automatic drive(input bit sel, input bit st, input bit cn, input bit sp, input bit dr);
      if (sel) begin
         start_b = st; cont_b = cn; stop_b = sp; dir_b = dr;
      end else begin
         start_a = st; cont_a = cn; stop_a = sp; dir_a = dr;
      end
   endtask

   // Entered and left on a falling edge; inputs change there, outputs are sampled there.
   task automatic run_seq(input bit sel, input string tag, input bit dir, input bit cn,
                          input int nfr, input int lines, input int vbl, input int tmax,
                          input int hold_until, input int stop_at, input int rst_at,
                          input bit tog);
      logic [15:0] e;
      bit d;
      for (int t = 1; t <= tmax; t++) q_exp.push_back(exp_vec(t, dir, nfr, lines, vbl));
      d = dir;
      drive(sel, 1'b1, cn, 1'b0, d);
      for (int t = 1; t <= tmax; t++) begin
         @(posedge clk);
         @(negedge clk);
         e = q_exp.pop_front();
         check(tag, t, sel ? obs_b : obs_a, e);
         if (t == rst_at) begin
            rst_n = 1'b0;
            #1;
            check({tag, "_async"}, t, obs_a, 16'h1000);
            q_exp.delete();
            break;
         end
         if (tog && (t % 7 == 0)) d = ~d;
         drive(sel, t < hold_until, cn, t == stop_at, d);
      end
      drive(sel, 1'b0, 1'b0, 1'b0, d);
      if (rst_at > 0) begin
         repeat (2) @(negedge clk);
         check({tag, "_held"}, 0, obs_a, 16'h1000);
         rst_n = 1'b1;
         repeat (3) @(negedge clk);
         check({tag, "_idle"}, 0, obs_a, 16'h1000);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("reset_a", 0, obs_a, 16'h1000);
      check("reset_b", 0, obs_b, 16'h1000);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_a", 0, obs_a, 16'h1000);

      run_seq(1'b0, "oneshot_td", 1'b0, 1'b0, 1, 8, 2, 130, 1, 0, 0, 1'b0);
      run_seq(1'b0, "oneshot_bu", 1'b1, 1'b0, 1, 8, 2, 130, 1, 0, 0, 1'b0);
      run_seq(1'b0, "cont_stop", 1'b0, 1'b1, 2, 8, 2, 250, 1, 176, 0, 1'b0);
      run_seq(1'b0, "busy_ignore", 1'b0, 1'b0, 1, 8, 2, 130, 100, 0, 0, 1'b1);
      run_seq(1'b0, "rst_mid", 1'b1, 1'b0, 1, 8, 2, 130, 1, 0, 47, 1'b0);
      run_seq(1'b0, "after_rst", 1'b0, 1'b0, 1, 8, 2, 130, 1, 0, 0, 1'b0);
      run_seq(1'b1, "vb0_cont", 1'b0, 1'b1, 100, 4, 0, TB_G + 1 + 3 * 48 + 5, 1, 0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
